// File: rtl/fib_step_engine.sv
// -----------------------------------------------------------------------------
// fib_step_engine
//   Sequential single-adder Fibonacci-style step engine. It accepts a seed
//   pair (a, b) and iterates (x, y) <- (y, x + y), one step per clock, for a
//   programmable number of steps. A single ALU instance performs every add.
//   With steps = 4 the result equals the combinational four-add chain.
//
//   Optional feature macro: FIB_OVF_FLAG_EN
//     When defined, adds port ovf_o: a sticky carry-out flag for the current
//     run. It is cleared on an accepted start, valid with done_o, and held
//     with result_o. When undefined, neither the port nor the carry logic
//     exists.
//
// Parameters
//   WIDTH    operand / result width
//   CNT_W    step-count width (max run 2^CNT_W - 1 steps)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start_i    in   run request, sampled only in IDLE
//   a_i        in   first seed operand (sampled on accepted start)
//   b_i        in   second seed operand (sampled on accepted start)
//   steps_i    in   number of add iterations (sampled on accepted start)
//   busy_o     out  high in RUN and DONE
//   done_o     out  one-cycle pulse, result_o valid in that cycle
//   result_o   out  final y value, held until the next completed run
//   ovf_o      out  sticky carry flag (FIB_OVF_FLAG_EN only)
// -----------------------------------------------------------------------------

// Minimal ALU slice: only the add opcode is implemented; any other opcode
// yields zero.
module fib_alu #(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
`ifdef FIB_OVF_FLAG_EN
    output logic             carry_o,
`endif
    output logic [WIDTH-1:0] y_o
);
    localparam logic [4:0] OP_ADD = 5'h01;

`ifdef FIB_OVF_FLAG_EN
    logic [WIDTH:0] sum_w;

    always_comb begin
        sum_w = '0;
        if (op_i == OP_ADD) begin
            sum_w = {1'b0, a_i} + {1'b0, b_i};
        end
    end

    assign y_o     = sum_w[WIDTH-1:0];
    assign carry_o = sum_w[WIDTH];
`else
    always_comb begin
        y_o = '0;
        if (op_i == OP_ADD) begin
            y_o = a_i + b_i;
        end
    end
`endif
endmodule

module fib_step_engine #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [CNT_W-1:0] steps_i,
    output logic             busy_o,
    output logic             done_o,
`ifdef FIB_OVF_FLAG_EN
    output logic             ovf_o,
`endif
    output logic [WIDTH-1:0] result_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [4:0] OP_ADD = 5'h01;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] sum_w;

`ifdef FIB_OVF_FLAG_EN
    logic             ovf_q, ovf_d;
    logic             carry_w;
`endif

    fib_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i    (OP_ADD),
        .a_i     (x_q),
        .b_i     (y_q),
`ifdef FIB_OVF_FLAG_EN
        .carry_o (carry_w),
`endif
        .y_o     (sum_w)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        result_d = result_q;
`ifdef FIB_OVF_FLAG_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    x_d   = a_i;
                    y_d   = b_i;
                    cnt_d = steps_i;
`ifdef FIB_OVF_FLAG_EN
                    ovf_d = 1'b0;
`endif
                    // A zero-step run skips RUN; the answer is the seed b.
                    if (steps_i == '0) begin
                        result_d = b_i;
                        state_d  = DONE;
                    end else begin
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                x_d   = y_q;
                y_d   = sum_w;
                cnt_d = cnt_q - 1'b1;
`ifdef FIB_OVF_FLAG_EN
                ovf_d = ovf_q | carry_w;
`endif
                // cnt is never 0 in RUN, so the count cannot wrap.
                if (cnt_q == CNT_W'(1)) begin
                    result_d = sum_w;
                    state_d  = DONE;
                end
            end
            DONE: begin
                // Always pass through IDLE: start is not accepted here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
`ifdef FIB_OVF_FLAG_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
`ifdef FIB_OVF_FLAG_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Pure decodes of registered state: no input-to-output path.
    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;
`ifdef FIB_OVF_FLAG_EN
    assign ovf_o    = ovf_q;
`endif
endmodule

// File: tb/tb_fib_step_engine.sv
// -----------------------------------------------------------------------------
// tb_fib_step_engine
//   Self-checking bench for fib_step_engine. A plain-arithmetic reference
//   (iterated Fibonacci on 64-bit integers) predicts result, carry flag,
//   done latency and busy length. Honours FIB_OVF_FLAG_EN for ovf checks.
// -----------------------------------------------------------------------------
module tb_fib_step_engine;
    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    logic             clk;
    logic             rst_n;
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [CNT_W-1:0] steps_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             ovf_o;

    int tests;
    int fails;

    fib_step_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .steps_i  (steps_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
`ifdef FIB_OVF_FLAG_EN
        .ovf_o    (ovf_o),
`endif
        .result_o (result_o)
    );

`ifndef FIB_OVF_FLAG_EN
    assign ovf_o = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {carry_seen, final_y}. Zero steps returns b with no carry.
    function automatic logic [WIDTH:0] ref_fib(input logic [WIDTH-1:0] av,
                                               input logic [WIDTH-1:0] bv,
                                               input int n);
        longint unsigned x, y, s;
        logic c;
        x = av; y = bv; c = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = x + y;
            if (s >= 64'h1_0000_0000) c = 1'b1;
            x = y;
            y = s & 64'hFFFF_FFFF;
        end
        return {c, y[WIDTH-1:0]};
    endfunction

    // Drives one run and measures it; no comparisons here.
    // done_at: sample index (0 = just after accept edge) of first done.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [CNT_W-1:0] sv,
                          output int done_at, output int busy_n, output int done_n,
                          output logic [WIDTH-1:0] res, output logic ov);
        done_at = -1; busy_n = 0; done_n = 0; res = '0; ov = 1'b0;
        @(negedge clk);
        a_i = av; b_i = bv; steps_i = sv; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy_o) busy_n++;
            if (done_o) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = i;
                    res = result_o;
                    ov = ovf_o;
                end
            end
            if (!busy_o) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0; steps_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({busy_o, done_o, result_o, ovf_o} !== '0) begin
            fails++;
            $display("FAIL reset_state: busy=%0b done=%0b result=%0h ovf=%0b, want all 0",
                     busy_o, done_o, result_o, ovf_o);
        end
        rst_n = 1'b1;
    endtask

    // One directed run checked against the reference and latency rules.
    task automatic test_directed_one(input string nm, input logic [WIDTH-1:0] av,
                                     input logic [WIDTH-1:0] bv, input int sv);
        int dat, bn, dn;
        logic [WIDTH-1:0] res;
        logic ov;
        logic [WIDTH:0] exp;
        exp = ref_fib(av, bv, sv);
        run_op(av, bv, CNT_W'(sv), dat, bn, dn, res, ov);
        tests++;
        if (res !== exp[WIDTH-1:0]) begin
            fails++;
            $display("FAIL %s result: got %0h want %0h", nm, res, exp[WIDTH-1:0]);
        end
        tests++;
        if (dat !== sv) begin
            fails++;
            $display("FAIL %s done_latency: got %0d want %0d", nm, dat, sv);
        end
        tests++;
        if (bn !== sv + 1 || dn !== 1) begin
            fails++;
            $display("FAIL %s busy/done cycles: got %0d/%0d want %0d/1", nm, bn, dn, sv + 1);
        end
`ifdef FIB_OVF_FLAG_EN
        tests++;
        if (ov !== exp[WIDTH]) begin
            fails++;
            $display("FAIL %s ovf: got %0b want %0b", nm, ov, exp[WIDTH]);
        end
`endif
    endtask

    task automatic test_directed;
        test_directed_one("fib4",   32'd1, 32'd1, 4);
        test_directed_one("fib10",  32'd0, 32'd1, 10);
        test_directed_one("zero",   32'd5, 32'd7, 0);
        test_directed_one("maxcnt", 32'd0, 32'd1, 31);
    endtask

    task automatic test_overflow;
        test_directed_one("wrap",   32'hFFFF_FFFF, 32'd1, 1);
        test_directed_one("ovfclr", 32'd1, 32'd1, 4);
        // Hard constants for the wrap case independent of the model.
        tests++;
        if (ref_fib(32'hFFFF_FFFF, 32'd1, 1) !== {1'b1, 32'd0}) begin
            fails++;
            $display("FAIL wrap_ref: got %0h want 100000000", ref_fib(32'hFFFF_FFFF, 32'd1, 1));
        end
    endtask

    task automatic test_ignore_start;
        logic [WIDTH:0] exp;
        int dat;
        logic [WIDTH-1:0] res;
        exp = ref_fib(32'd3, 32'd4, 20);
        dat = -1; res = '0;
        @(negedge clk);
        a_i = 32'd3; b_i = 32'd4; steps_i = 5'd20; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i == 5) begin
                a_i = 32'd100; b_i = 32'd200; steps_i = 5'd2; start_i = 1'b1;
            end
            if (i == 8) start_i = 1'b0;
            if (done_o && dat < 0) begin dat = i; res = result_o; end
            if (!busy_o) break;
            @(posedge clk); #1;
        end
        tests++;
        if (res !== exp[WIDTH-1:0] || dat !== 20) begin
            fails++;
            $display("FAIL ignore_start: result=%0h at %0d want %0h at 20",
                     res, dat, exp[WIDTH-1:0]);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL ignore_start_idle: busy=%0b want 0", busy_o);
        end
    endtask

    // start held high: one accept per steps+2 cycles, start dropped in DONE.
    task automatic test_back_to_back;
        int dones[$];
        logic [WIDTH:0] exp;
        exp = ref_fib(32'd2, 32'd3, 3);
        @(negedge clk);
        a_i = 32'd2; b_i = 32'd3; steps_i = 5'd3; start_i = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            if (done_o) begin
                dones.push_back(i);
                tests++;
                if (result_o !== exp[WIDTH-1:0]) begin
                    fails++;
                    $display("FAIL b2b_result: got %0h want %0h", result_o, exp[WIDTH-1:0]);
                end
            end
        end
        start_i = 1'b0;
        tests++;
        if (dones.size() < 3) begin
            fails++;
            $display("FAIL b2b_count: got %0d dones want >=3", dones.size());
        end else begin
            for (int k = 1; k < dones.size(); k++) begin
                tests++;
                if (dones[k] - dones[k-1] !== 5) begin
                    fails++;
                    $display("FAIL b2b_interval: got %0d want 5", dones[k] - dones[k-1]);
                end
            end
        end
        for (int i = 0; i < 20 && busy_o; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midrun;
        int dat, bn, dn, seen;
        logic [WIDTH-1:0] res;
        logic ov;
        // Leave a non-zero result so the async clear is observable.
        test_directed_one("pre_rst", 32'd1, 32'd2, 3);
        @(negedge clk);
        a_i = 32'd0; b_i = 32'd1; steps_i = 5'd10; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== '0) begin
            fails++;
            $display("FAIL async_reset: busy=%0b done=%0b result=%0h want 0/0/0",
                     busy_o, done_o, result_o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done_o || busy_o) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL reset_abandon: busy/done seen %0d cycles want 0", seen);
        end
        test_directed_one("post_rst", 32'd0, 32'd1, 10);
    endtask

    task automatic test_random;
        for (int n = 0; n < 25; n++) begin
            logic [WIDTH-1:0] av, bv;
            int sv;
            av = $urandom;
            bv = $urandom;
            sv = (n % 5 == 0) ? 0 : int'($urandom_range(1, 31));
            test_directed_one("random", av, bv, sv);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
